instr_stream_encoder: RTL and testbench

- Encoder and program loader for the decode stage's instruction format: the write-side counterpart of the control unit.
- Accepts instruction fields (branch flag, immediate flag, 3-bit opcode, register fields, immediate) over a valid/ready stream and packs them into 32-bit instruction words.
- Buffers words in a small FIFO and writes them sequentially into instruction memory starting at a programmed base address.
- Used by the test/boot path to load programs before the core is released.

---
 rtl/instr_stream_encoder.sv | 211 +++++++++++++++++++++
 tb/tb_instr_stream_encoder.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_encoder.sv
// Instruction stream encoder and program loader.
// Packs field bundles into 32-bit words, buffers them, and writes memory.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse, begins a session at base_addr
//   base_addr       first memory word address of the session
//   in_valid/ready  field bundle handshake
//   in_branch       branch-class flag (word bit 31)
//   in_imm          immediate flag (word bit 30)
//   in_code         3-bit opcode (word bits 29:27)
//   in_rd/rs1/rs2   register fields
//   in_immval       19-bit immediate
//   in_last         final bundle of the program
//   mem_stall       memory cannot take a write this cycle
//   mem_we/addr/wdata  registered memory write port
//   busy/done/err   session status; done and err held until next start
//   count           words written this session
module instr_stream_encoder #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_branch,
    input  logic               in_imm,
    input  logic [2:0]         in_code,
    input  logic [3:0]         in_rd,
    input  logic [3:0]         in_rs1,
    input  logic [3:0]         in_rs2,
    input  logic [18:0]        in_immval,
    input  logic               in_last,
    input  logic               mem_stall,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W-1:0]  count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
    localparam logic [PW:0]       OCC_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]       OCC_FULL = (PW + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_count;
    logic                r_last_seen;
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [PW:0]         r_occ;
    logic                r_full;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [INSTR_W-1:0]  r_mem_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [INSTR_W-1:0]  r_fifo [DEPTH];

    logic [18:0]         w_field;
    logic [INSTR_W-1:0]  w_word;
    logic                w_legal;
    logic                w_run;
    logic                w_ready;
    logic                w_hs;
    logic                w_push;
    logic                w_bad;
    logic                w_empty;
    logic [ADDR_W:0]     w_sum;
    logic                w_ovf;
    logic                w_want;
    logic                w_pop;
    logic [PW:0]         w_occ_nxt;

    // Immediate form carries immval; register form zero-pads rs2.
    assign w_field = in_imm ? in_immval : {15'b0, in_rs2};
    assign w_word  = {in_branch, in_imm, in_code, in_rd, in_rs1, w_field};

    // Branches may only use codes x00.
    assign w_legal = !(in_branch && (in_code[1:0] != 2'b00));

    // Ready depends only on registered state, never on in_valid.
    assign w_run   = (r_state == S_RUN);
    assign w_ready = w_run && !r_full && !r_last_seen;
    assign w_hs    = in_valid && w_ready;
    assign w_push  = w_hs && w_legal;
    assign w_bad   = w_hs && !w_legal;

    // One extra bit catches the address wrapping past the top.
    assign w_empty = (r_occ == '0);
    assign w_sum   = {1'b0, r_base} + {1'b0, r_count};
    assign w_ovf   = w_sum[ADDR_W];
    assign w_want  = w_run && !w_empty && !mem_stall;
    assign w_pop   = w_want && !w_ovf;

    always_comb begin
        w_occ_nxt = r_occ;
        unique case ({w_push, w_pop})
            2'b10:   w_occ_nxt = r_occ + OCC_ONE;
            2'b01:   w_occ_nxt = r_occ - OCC_ONE;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Storage only; validity is tracked by the pointers and occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_count     <= '0;
            r_last_seen <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_occ       <= '0;
            r_full      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_base      <= base_addr;
                        r_count     <= '0;
                        r_last_seen <= 1'b0;
                        r_wptr      <= '0;
                        r_rptr      <= '0;
                        r_occ       <= '0;
                        r_full      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_push) begin
                        r_wptr <= r_wptr + PTR_ONE;
                        if (in_last) begin
                            r_last_seen <= 1'b1;
                        end
                    end
                    if (w_pop) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_sum[ADDR_W-1:0];
                        r_mem_wdata <= r_fifo[r_rptr];
                        r_rptr      <= r_rptr + PTR_ONE;
                        r_count     <= r_count + CNT_ONE;
                    end
                    r_occ  <= w_occ_nxt;
                    r_full <= (w_occ_nxt == OCC_FULL);
                    // A write already committed this cycle still lands;
                    // everything left in the buffer is dropped.
                    if (w_bad || (w_want && w_ovf)) begin
                        r_state <= S_ERR;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_wptr  <= '0;
                        r_rptr  <= '0;
                        r_occ   <= '0;
                        r_full  <= 1'b0;
                    end else if (r_last_seen && w_pop &&
                                 (w_occ_nxt == '0)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign count     = r_count;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: encoding table plus
// stall, illegal, overflow and reset sequences.
module tb_instr_stream_encoder;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic          in_branch;
    logic          in_imm;
    logic [2:0]    in_code;
    logic [3:0]    in_rd;
    logic [3:0]    in_rs1;
    logic [3:0]    in_rs2;
    logic [18:0]   in_immval;
    logic          in_last;
    logic          mem_stall;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] count;

    instr_stream_encoder #(
        .INSTR_W(32),
        .ADDR_W (AW),
        .DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_branch(in_branch),
        .in_imm   (in_imm),
        .in_code  (in_code),
        .in_rd    (in_rd),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_immval(in_immval),
        .in_last  (in_last),
        .mem_stall(mem_stall),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          br;
        logic          im;
        logic [2:0]    code;
        logic [3:0]    rd;
        logic [3:0]    rs1;
        logic [3:0]    rs2;
        logic [18:0]   iv;
        logic [AW-1:0] base;
        logic [31:0]   exp;
    } vec_t;

    vec_t vt[6];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    int            wc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic set_b(input vec_t v, input logic last);
        in_branch = v.br;
        in_imm    = v.im;
        in_code   = v.code;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_immval = v.iv;
        in_last   = last;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input vec_t v, input logic last);
        int k = 0;
        set_b(v, last);
        in_valid = 1'b1;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready 0 required 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input int n);
        int k = 0;
        while (!done && !err && k < n) begin
            tick();
            k++;
        end
        if (!done && !err) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: done/err 0 required 1");
        end
    endtask

    function automatic vec_t mk(input logic br, input logic im,
                                input logic [2:0] code,
                                input logic [3:0] rd,
                                input logic [3:0] rs1,
                                input logic [3:0] rs2,
                                input logic [18:0] iv,
                                input logic [AW-1:0] base,
                                input logic [31:0] exp);
        vec_t v;
        v.br = br; v.im = im; v.code = code;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.iv = iv; v.base = base; v.exp = exp;
        return v;
    endfunction

    // MOV-immediate used in streamed sequences.
    function automatic vec_t mov(input int i);
        logic [31:0] e;
        e = 32'h6000_0000 | (32'(i) << 23) | (32'h100 + 32'(i));
        return mk(1'b0, 1'b1, 3'b100, 4'(i), 4'h0, 4'h0,
                  19'(32'h100 + 32'(i)), '0, e);
    endfunction

    initial begin
        int i;
        int g;
        logic acc;
        vec_t v;

        vt[0] = mk(0, 0, 3'b001, 4'd3, 4'd4, 4'd5,
                   19'h0, 10'h010, 32'h09A0_0005);
        vt[1] = mk(1, 1, 3'b100, 4'd0, 4'd0, 4'd0,
                   19'h7FFFF, 10'h011, 32'hE007_FFFF);
        vt[2] = mk(0, 0, 3'b010, 4'hF, 4'hF, 4'hF,
                   19'h0, 10'h200, 32'h17F8_000F);
        vt[3] = mk(0, 1, 3'b111, 4'd1, 4'd2, 4'hF,
                   19'h12345, 10'h3FF, 32'h7891_2345);
        vt[4] = mk(1, 0, 3'b000, 4'd0, 4'd0, 4'hA,
                   19'h0, 10'h000, 32'h8000_000A);
        vt[5] = mk(0, 0, 3'b101, 4'd2, 4'd3, 4'd4,
                   19'h7FFFF, 10'h155, 32'h2918_0004);

        rst = 1'b1; start = 1'b0; base_addr = '0;
        in_valid = 1'b0; mem_stall = 1'b0;
        set_b(vt[0], 1'b0);
        tick();
        tick();
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", in_ready, 0);
        rst = 1'b0;
        tick();
        chk("idle_ready", in_ready, 0);

        // Encoding table: one-word sessions.
        for (int n = 0; n < 6; n++) begin
            clear_log();
            do_start(vt[n].base);
            send(vt[n], 1'b1);
            chk("nobypass", mem_we, 0);
            wait_end(20);
            tick();
            chk("vec_nwr", wa_q.size(), 1);
            if (wa_q.size() > 0) begin
                chk("vec_addr", wa_q[0], vt[n].base);
                chk("vec_data", wd_q[0], vt[n].exp);
            end
            chk("vec_done", done, 1);
            chk("vec_busy", busy, 0);
            chk("vec_count", count, 1);
        end

        // Six MOVs against an 8-cycle stall.
        clear_log();
        mem_stall = 1'b1;
        do_start(10'h100);
        i = 0;
        for (int k = 0; k < 8; k++) begin
            v = mov(i);
            set_b(v, i == 5);
            in_valid = (i < 6);
            acc = in_ready && in_valid;
            tick();
            if (acc) i++;
        end
        chk("stall_accepts", i, 4);
        chk("stall_ready", in_ready, 0);
        chk("stall_nowr", wa_q.size(), 0);
        chk("stall_count", count, 0);
        mem_stall = 1'b0;
        g = 0;
        while (i < 6 && g < 50) begin
            v = mov(i);
            set_b(v, i == 5);
            in_valid = 1'b1;
            acc = in_ready;
            tick();
            if (acc) i++;
            g++;
        end
        in_valid = 1'b0;
        wait_end(50);
        tick();
        chk("stream_nwr", wa_q.size(), 6);
        if (wa_q.size() == 6) begin
            for (int j = 0; j < 6; j++) begin
                v = mov(j);
                chk("stream_addr", wa_q[j], 10'h100 + 10'(j));
                chk("stream_data", wd_q[j], v.exp);
                chk("stream_cyc", wc_q[j] - wc_q[0], j);
            end
        end
        chk("stream_done", done, 1);
        chk("stream_count", count, 6);

        // Illegal branch as third bundle.
        clear_log();
        do_start(10'h020);
        send(mov(0), 1'b0);
        send(mov(1), 1'b0);
        v = mk(1, 0, 3'b001, 4'd1, 4'd1, 4'd1,
               19'h0, '0, '0);
        send(v, 1'b1);
        tick();
        tick();
        tick();
        chk("ill_err", err, 1);
        chk("ill_ready", in_ready, 0);
        chk("ill_busy", busy, 0);
        chk("ill_nwr", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            v = mov(1);
            chk("ill_a0", wa_q[0], 10'h020);
            chk("ill_a1", wa_q[1], 10'h021);
            chk("ill_d1", wd_q[1], v.exp);
        end
        do_start(10'h030);
        chk("rec_busy", busy, 1);
        chk("rec_err", err, 0);
        clear_log();
        send(mov(2), 1'b1);
        wait_end(20);
        tick();
        chk("rec_done", done, 1);
        chk("rec_nwr", wa_q.size(), 1);
        if (wa_q.size() > 0) chk("rec_addr", wa_q[0], 10'h030);

        // Address overflow at the top of memory.
        clear_log();
        do_start(10'h3FE);
        send(mov(0), 1'b0);
        send(mov(1), 1'b0);
        send(mov(2), 1'b1);
        wait_end(20);
        tick();
        tick();
        chk("ovf_err", err, 1);
        chk("ovf_done", done, 0);
        chk("ovf_count", count, 2);
        chk("ovf_nwr", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            chk("ovf_a0", wa_q[0], 10'h3FE);
            chk("ovf_a1", wa_q[1], 10'h3FF);
        end

        // Reset with three words buffered.
        clear_log();
        mem_stall = 1'b1;
        do_start(10'h040);
        send(mov(0), 1'b0);
        send(mov(1), 1'b0);
        send(mov(2), 1'b0);
        rst = 1'b1;
        tick();
        chk("mrst_we", mem_we, 0);
        chk("mrst_addr", mem_addr, 0);
        chk("mrst_wdata", mem_wdata, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_count", count, 0);
        chk("mrst_ready", in_ready, 0);
        rst = 1'b0;
        mem_stall = 1'b0;
        tick();
        tick();
        tick();
        chk("mrst_nowr", wa_q.size(), 0);
        do_start(10'h050);
        send(vt[2], 1'b1);
        wait_end(20);
        tick();
        chk("mrst_nwr", wa_q.size(), 1);
        if (wa_q.size() > 0) begin
            chk("mrst_a", wa_q[0], 10'h050);
            chk("mrst_d", wd_q[0], vt[2].exp);
        end
        chk("mrst_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
